// File: rtl/onehot_decoder_accum_if.sv
// Valid/ready bundle for the one-hot decoder/accumulator: index beats in, one-hot results out.
// The master drives beats and result back-pressure; the slave is the decoder.
interface onehot_decoder_accum_if #(
   parameter int IDX_W = 3
);
   localparam int OUT_W = 1 << IDX_W;

   logic             mode;
   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] in_index;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_onehot;
   logic [IDX_W:0]   out_count;
   logic             out_dup;

   modport master (
      output mode, in_valid, in_index, in_last, out_ready,
      input  in_ready, out_valid, out_onehot, out_count, out_dup
   );

   modport slave (
      input  mode, in_valid, in_index, in_last, out_ready,
      output in_ready, out_valid, out_onehot, out_count, out_dup
   );
endinterface

// File: rtl/onehot_decoder_accum.sv
// Binary-index to one-hot decoder; in accumulate mode ORs a frame of indices into one request
// mask with popcount and duplicate detection. Results are registered behind valid/ready.
module onehot_decoder_accum #(
   parameter int IDX_W = 3
) (
   input logic                    clk,
   input logic                    rst_n,
   onehot_decoder_accum_if.slave  bus
);
   localparam int OUT_W = 1 << IDX_W;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [OUT_W-1:0] acc_reg, acc_next;
   logic             dup_reg, dup_next;
   logic             mode_reg, mode_next;
   logic             out_valid_reg, out_valid_next;
   logic [OUT_W-1:0] out_onehot_reg, out_onehot_next;
   logic [IDX_W:0]   out_count_reg, out_count_next;
   logic             out_dup_reg, out_dup_next;

   logic [OUT_W-1:0] dec;
   logic [OUT_W-1:0] base_acc;
   logic [OUT_W-1:0] new_acc;
   logic             base_dup;
   logic             new_dup;
   logic             mode_eff;
   logic             close_frame;
   logic             ready;
   logic             accept;

   function automatic logic [IDX_W:0] popcount(input logic [OUT_W-1:0] v);
      logic [IDX_W:0] c;
      c = '0;
      for (int i = 0; i < OUT_W; i++) begin
         c = c + (IDX_W+1)'(v[i]);
      end
      return c;
   endfunction

   for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
      assign dec[gi] = (bus.in_index == IDX_W'(gi));
   end

   assign ready  = !out_valid_reg || bus.out_ready;
   assign accept = bus.in_valid && ready;

   // A beat in IDLE starts from an empty mask, so single-mode words and one-beat frames
   // fall out of the same OR/dup path as the last beat of a longer frame.
   assign mode_eff    = (state_reg == IDLE) ? bus.mode : mode_reg;
   assign base_acc    = (state_reg == ACCUM) ? acc_reg : '0;
   assign base_dup    = (state_reg == ACCUM) && dup_reg;
   assign new_acc     = base_acc | dec;
   assign new_dup     = base_dup || (|(base_acc & dec));
   assign close_frame = !mode_eff || bus.in_last;

   always_comb begin
      state_next      = state_reg;
      acc_next        = acc_reg;
      dup_next        = dup_reg;
      mode_next       = mode_reg;
      out_valid_next  = out_valid_reg && !bus.out_ready;
      out_onehot_next = out_onehot_reg;
      out_count_next  = out_count_reg;
      out_dup_next    = out_dup_reg;

      if (accept) begin
         mode_next = mode_eff;
         if (close_frame) begin
            out_valid_next  = 1'b1;
            out_onehot_next = new_acc;
            out_count_next  = popcount(new_acc);
            out_dup_next    = new_dup;
            acc_next        = '0;
            dup_next        = 1'b0;
            state_next      = IDLE;
         end else begin
            acc_next   = new_acc;
            dup_next   = new_dup;
            state_next = ACCUM;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         acc_reg        <= '0;
         dup_reg        <= 1'b0;
         mode_reg       <= 1'b0;
         out_valid_reg  <= 1'b0;
         out_onehot_reg <= '0;
         out_count_reg  <= '0;
         out_dup_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         acc_reg        <= acc_next;
         dup_reg        <= dup_next;
         mode_reg       <= mode_next;
         out_valid_reg  <= out_valid_next;
         out_onehot_reg <= out_onehot_next;
         out_count_reg  <= out_count_next;
         out_dup_reg    <= out_dup_next;
      end
   end

   assign bus.in_ready   = ready;
   assign bus.out_valid  = out_valid_reg;
   assign bus.out_onehot = out_onehot_reg;
   assign bus.out_count  = out_count_reg;
   assign bus.out_dup    = out_dup_reg;
endmodule

// File: tb/tb_onehot_decoder_accum.sv
// Bench for onehot_decoder_accum: frame-level reference model checked every cycle,
// directed scenarios pinned with literal results, then a randomized stall/reset soak.
module tb_onehot_decoder_accum;
   localparam int IDX_W = 3;

   typedef struct {
      logic [7:0] oh;
      logic [3:0] cnt;
      logic       dup;
   } res_t;

   logic clk;
   logic rst_n;

   onehot_decoder_accum_if #(.IDX_W(IDX_W)) bus ();

   onehot_decoder_accum #(.IDX_W(IDX_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit         model_ok = 0;
   bit         exp_valid = 0;
   bit         exp_zero = 0;
   logic [7:0] exp_oh = '0;
   int         exp_cnt = 0;
   bit         exp_dup = 0;
   bit         in_frame = 0;
   bit         m_mode = 0;
   int         frame[$];
   res_t       mdl_last;
   res_t       dut_log[$];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // A frame's result: the set of distinct indices seen, how many, and whether any repeated.
   function automatic void model_close();
      int         seen[8];
      logic [7:0] vec;
      int         n;
      bit         d;
      vec = '0;
      n = 0;
      d = 0;
      foreach (seen[k]) seen[k] = 0;
      foreach (frame[k]) begin
         seen[frame[k]]++;
      end
      for (int k = 0; k < 8; k++) begin
         if (seen[k] > 0) begin
            n++;
            vec = vec | (8'(1) << k);
         end
         if (seen[k] > 1) d = 1;
      end
      exp_valid = 1;
      exp_zero = 0;
      exp_oh = vec;
      exp_cnt = n;
      exp_dup = d;
      mdl_last.oh = vec;
      mdl_last.cnt = 4'(n);
      mdl_last.dup = d;
      frame.delete();
      in_frame = 0;
   endfunction

   // Inputs change only at posedge+1, so the values seen at a negedge are the ones the next
   // posedge will act on: compare first, then advance the model to that edge.
   initial begin
      forever begin
         @(negedge clk);
         if (model_ok) begin
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            if (rst_n) chk("in_ready", 32'(bus.in_ready), 32'(!exp_valid || bus.out_ready));
            if (exp_valid || exp_zero) begin
               chk("out_onehot", 32'(bus.out_onehot), 32'(exp_oh));
               chk("out_count", 32'(bus.out_count), 32'(exp_cnt));
               chk("out_dup", 32'(bus.out_dup), 32'(exp_dup));
            end
         end
         if (rst_n && bus.out_valid && bus.out_ready) begin
            res_t r;
            r.oh = bus.out_onehot;
            r.cnt = bus.out_count;
            r.dup = bus.out_dup;
            dut_log.push_back(r);
            $display("result onehot=0x%02h count=%0d dup=%0d at %0t", r.oh, r.cnt, r.dup, $time);
         end
         if (!rst_n) begin
            model_ok = 1;
            exp_valid = 0;
            exp_zero = 1;
            exp_oh = '0;
            exp_cnt = 0;
            exp_dup = 0;
            frame.delete();
            in_frame = 0;
            m_mode = 0;
         end else if (model_ok) begin
            bit rdy;
            rdy = !exp_valid || bus.out_ready;
            if (exp_valid && bus.out_ready) exp_valid = 0;
            if (bus.in_valid && rdy) begin
               if (!in_frame) m_mode = bus.mode;
               frame.push_back(int'(bus.in_index));
               if (!m_mode || bus.in_last) model_close();
               else in_frame = 1;
            end
         end
      end
   end

   task automatic beat(input int idx, input bit last, input bit md);
      bit took;
      int n;
      bus.in_valid = 1'b1;
      bus.in_index = idx[IDX_W-1:0];
      bus.in_last = last;
      bus.mode = md;
      took = 0;
      n = 0;
      while (!took) begin
         @(negedge clk);
         took = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
         if (!took && n > 100) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout actual=not_accepted required=accepted index=%0d", idx);
            break;
         end
      end
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
   endtask

   task automatic drain();
      idle();
      bus.out_ready = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic log_chk(input int i, input logic [7:0] oh, input int cnt, input bit dup);
      if (i >= dut_log.size()) begin
         checks++;
         errors++;
         $display("FAIL log_missing actual=%0d_entries required=entry_%0d", dut_log.size(), i);
      end else begin
         chk("log_onehot", 32'(dut_log[i].oh), 32'(oh));
         chk("log_count", 32'(dut_log[i].cnt), 32'(cnt));
         chk("log_dup", 32'(dut_log[i].dup), 32'(dup));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.mode = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_index = '0;
      bus.in_last = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_out_onehot", 32'(bus.out_onehot), 32'd0);
      chk("reset_out_count", 32'(bus.out_count), 32'd0);
      chk("reset_out_dup", 32'(bus.out_dup), 32'd0);
      @(posedge clk);
      #1;

      // single mode, back-to-back
      dut_log.delete();
      for (int i = 0; i < 8; i++) beat(i, 1'b0, 1'b0);
      drain();
      chk("single_log_size", 32'(dut_log.size()), 32'd8);
      for (int i = 0; i < 8; i++) log_chk(i, 8'(1) << i, 1, 0);

      // single mode under back-pressure
      dut_log.delete();
      bus.out_ready = 1'b0;
      beat(5, 1'b0, 1'b0);
      bus.in_index = 3'd2;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
         chk("stall_onehot", 32'(bus.out_onehot), 32'h20);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      beat(2, 1'b0, 1'b0);
      drain();
      chk("stall_log_size", 32'(dut_log.size()), 32'd2);
      log_chk(0, 8'h20, 1, 0);
      log_chk(1, 8'h04, 1, 0);
      chk("model_pin_stall", 32'(mdl_last.oh), 32'h04);

      // accumulate 1,3,6 with mode dropped mid-frame
      dut_log.delete();
      beat(1, 1'b0, 1'b1);
      beat(3, 1'b0, 1'b0);
      beat(6, 1'b1, 1'b0);
      drain();
      log_chk(0, 8'h4A, 3, 0);
      chk("model_pin_4a", 32'(mdl_last.oh), 32'h4A);

      // duplicate frame then single-beat frame
      dut_log.delete();
      beat(4, 1'b0, 1'b1);
      beat(4, 1'b0, 1'b1);
      beat(0, 1'b1, 1'b1);
      beat(7, 1'b1, 1'b1);
      drain();
      chk("dup_log_size", 32'(dut_log.size()), 32'd2);
      log_chk(0, 8'h11, 2, 1);
      log_chk(1, 8'h80, 1, 0);
      chk("model_pin_dup", 32'(mdl_last.dup), 32'd0);

      // all eight indices
      dut_log.delete();
      for (int i = 0; i < 8; i++) beat(i, i == 7, 1'b1);
      drain();
      log_chk(0, 8'hFF, 8, 0);
      chk("model_pin_full", 32'(mdl_last.cnt), 32'd8);

      // reset discards a partial frame
      dut_log.delete();
      beat(2, 1'b0, 1'b1);
      beat(5, 1'b0, 1'b1);
      idle();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_reset_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      beat(1, 1'b1, 1'b1);
      drain();
      chk("reset_log_size", 32'(dut_log.size()), 32'd1);
      log_chk(0, 8'h02, 1, 0);

      // randomized soak: random valid/ready/mode/last with rare resets
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.in_index = 3'($urandom_range(0, 7));
         bus.in_last = ($urandom_range(0, 2) == 0);
         bus.mode = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
